load_store_unit: RTL
====================

# load_store_unit

Data-memory stage of the single-cycle RV32I core: consumes the decoded instruction (func7+func3+opcode), the ALU-computed effective address and the rs2 store value, runs a valid/ready request plus response transaction to data memory, and returns the aligned, sign/zero-extended load value to the rd write-back mux (memory_out input, select 10). While an access is in flight it holds `stall` high so the program counter and register file hold state. Misaligned accesses are flagged without a bus access; an unresponsive bus is bounded by a timeout.

## Interface
- RSP_TIMEOUT, 255: max cycles spent in REQ+WAIT before aborting with bus_error (1..65535)
- clk  in  1  core clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- full_inst  in  17  {func7[16:10], func3[9:7], opcode[6:0]} from decoder
- addr  in  32  effective address (ALU output)
- store_data  in  32  rs2 value
- stall  out  1  high: core must not advance PC nor write rd
- mem_out  out  32  load result to write-back mux; valid while mem_out_valid
- mem_out_valid  out  1  one-cycle pulse in the retiring cycle of a load
- misalign  out  1  combinational; current memory instruction is misaligned
- bus_error  out  1  one-cycle pulse in the retiring cycle after a timeout
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = store
- mem_req_addr  out  32  {addr[31:2], 2'b00}
- mem_req_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_req_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  response or write-ack present
- mem_rsp_rdata  in  32  read data

## Operation
- Decode: load = opcode 0000011 with func3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}; store = opcode 0100011 with func3 in {000 SB, 001 SH, 010 SW}. Anything else: not a memory op; stall=0, no bus activity.
- Misalign: H-ops with addr[0]=1, W-ops with addr[1:0]≠0. misalign=1, stall=0, no request, mem_out=0, mem_out_valid=0; instruction retires in that cycle.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE: aligned memory op present -> latch addr, we, func3, be, wdata; go REQ. stall=1.
  - REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready -> WAIT. stall=1.
  - WAIT: on mem_rsp_valid -> capture extracted data, go DONE. stall=1.
  - DONE: stall=0, mem_out_valid=1 (loads only), mem_out holds captured value; next -> IDLE.
  - Timeout counter clears on IDLE->REQ, increments each REQ/WAIT cycle; on reaching RSP_TIMEOUT -> DONE with bus_error=1, mem_out=0, mem_out_valid=0.
- stall = memory op decoded, aligned, and state ≠ DONE (combinational, so the PC edge is blocked in the detect cycle).
- Store lanes: SB be=1<<addr[1:0], wdata={4{sd[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{sd[15:0]}}; SW be=1111, wdata=sd. Loads: be=1111, wdata=0.
- Load extract: lane = rdata>>(8*addr[1:0]); LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW as-is.
- mem_rsp_valid outside WAIT is ignored; mem_req_ready outside REQ ignored.

## Timing
- Reset (async, any state incl. mid-transaction): state IDLE, counter 0, mem_out=0, mem_out_valid=0, bus_error=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_be=0, mem_req_wdata=0; an abandoned request is dropped without handshake.
- Min latency: detect cycle 0 (IDLE), REQ cycle 1 with ready, rsp in cycle 2, DONE cycle 3 -> instruction occupies 4 cycles; retires at end of cycle 3.
- Back-to-back memory ops: second op detected in the IDLE cycle immediately after DONE.
- Request fields latched at IDLE->REQ; later changes on addr/store_data do not affect the transaction.
- Response in the same cycle as ready is not accepted; first acceptable response is the cycle after the REQ handshake.

## Test plan
- Reset, then SW addr 0x100, sd 0xDEADBEEF, ready/rsp immediate -> req we=1, addr 0x100, be 1111, wdata 0xDEADBEEF; stall high 3 cycles, low in cycle 3.
- LB addr 0x103, rdata 0x80FF1234 -> mem_out 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SH addr 0x206, sd 0x0000ABCD -> be 1100, wdata 0xABCDABCD, addr 0x204; SB addr 0x201 -> be 0010.
- LW addr 0x102 -> misalign=1, stall=0, mem_req_valid never asserted.
- RSP_TIMEOUT=4, ready never asserted -> DONE after 4 REQ cycles, bus_error pulse, mem_out=0, stall drops.
- reset_n low while in WAIT with 3-cycle rsp delay -> immediate IDLE, all outputs 0; late rsp_valid ignored; next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory stage: decodes RV32I loads/stores, runs a valid/ready
// request plus response to data memory, returns the extended load value.
module load_store_unit #(
   parameter int unsigned RSP_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [16:0] full_inst,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] mem_out,
   output logic        mem_out_valid,
   output logic        misalign,
   output logic        bus_error,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [3:0]  mem_req_be,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic        is_load;
   logic        is_store;
   logic        is_mem;
   logic        mem_go;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [15:0] cnt;
   logic        tmo;
   logic        timeout_hit;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        ld_q;
   logic        err_q;
   logic [31:0] data_q;
   logic [31:0] lane;
   logic [31:0] ext;
   logic        unused_func7;

   assign opcode       = full_inst[6:0];
   assign func3        = full_inst[9:7];
   assign unused_func7 = ^full_inst[16:10];

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      if (opcode == 7'b0000011)
         is_load = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      if (opcode == 7'b0100011)
         is_store = func3 inside {3'b000, 3'b001, 3'b010};
   end

   assign is_mem = is_load | is_store;

   always_comb begin
      misalign = 1'b0;
      if (is_mem) begin
         case (func3[1:0])
            2'b01:   misalign = addr[0];
            2'b10:   misalign = |addr[1:0];
            default: misalign = 1'b0;
         endcase
      end
   end

   assign mem_go = is_mem & ~misalign;

   // Stores replicate the datum on every lane; byte enables pick the target.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = '0;
      if (is_store) begin
         case (func3[1:0])
            2'b00: begin
               be_d    = 4'b0001 << addr[1:0];
               wdata_d = {4{store_data[7:0]}};
            end
            2'b01: begin
               be_d    = addr[1] ? 4'b1100 : 4'b0011;
               wdata_d = {2{store_data[15:0]}};
            end
            default: wdata_d = store_data;
         endcase
      end
   end

   assign lane = mem_rsp_rdata >> {off_q, 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  ext = {24'd0, lane[7:0]};
         3'b101:  ext = {16'd0, lane[15:0]};
         default: ext = lane;
      endcase
   end

   assign tmo = (cnt >= 16'(RSP_TIMEOUT - 1));

   // A response in the last allowed cycle still completes normally.
   assign timeout_hit = ((state == REQ) && tmo) ||
                        ((state == WAIT) && !mem_rsp_valid && tmo);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (mem_go) state_nxt = REQ;
         REQ: begin
            if (tmo)                state_nxt = DONE;
            else if (mem_req_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid)      state_nxt = DONE;
            else if (tmo)           state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt           <= '0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_be    <= '0;
         mem_req_wdata <= '0;
         f3_q          <= '0;
         off_q         <= '0;
         ld_q          <= 1'b0;
         err_q         <= 1'b0;
         data_q        <= '0;
      end else begin
         if ((state == IDLE) && mem_go) begin
            cnt           <= '0;
            mem_req_we    <= is_store;
            mem_req_addr  <= {addr[31:2], 2'b00};
            mem_req_be    <= be_d;
            mem_req_wdata <= wdata_d;
            f3_q          <= func3;
            off_q         <= addr[1:0];
            ld_q          <= is_load;
            err_q         <= 1'b0;
            data_q        <= '0;
         end else if ((state == REQ) || (state == WAIT)) begin
            cnt <= cnt + 16'd1;
         end
         if (timeout_hit) begin
            err_q  <= 1'b1;
            data_q <= '0;
         end else if ((state == WAIT) && mem_rsp_valid) begin
            data_q <= ld_q ? ext : '0;
         end
      end
   end

   always_comb begin
      stall         = mem_go && (state != DONE);
      mem_req_valid = (state == REQ);
      mem_out_valid = (state == DONE) && ld_q && !err_q;
      bus_error     = (state == DONE) && err_q;
      mem_out       = (state == DONE) ? data_q : '0;
   end

endmodule
